// File: rtl/fp_div_pkg.sv
// Shared FP32 field constants, classification type and flag struct for the divider issue stage.
// Pure declarations: no latency, no backpressure.
package fp_div_pkg;

  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MAN_W   = 23;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    NORMAL = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fp_class_e;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
  } flags_t;

  // Denormals have exponent 0 and are deliberately reported as ZERO (flush).
  function automatic fp_class_e fp_classify(input logic [31:0] x);
    if (x[EXP_MSB:EXP_LSB] == '0) return ZERO;
    if (x[EXP_MSB:EXP_LSB] == '1) return (x[MAN_W-1:0] == '0) ? INF : NAN;
    return NORMAL;
  endfunction

endpackage

// File: rtl/fp_div_dispatch_if.sv
// Operand request and result response channels of the divider issue stage.
// Latency/backpressure are defined by the module on the slave side (valid/ready both ways).
interface fp_div_dispatch_if #(parameter int TAG_W = 4);
  import fp_div_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  flags_t           out_flags;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_flags
  );
endinterface

// File: rtl/fp_result_fifo.sv
// Generic sync-reset FIFO with registered head and occupancy count; head reads zero when empty.
// Latency: push visible at head the next cycle; backpressure: caller must not push when full.
module fp_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 38,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_vld = (count != '0);
  assign do_pop   = pop && head_vld;
  assign head_dat = head_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_next(wr_ptr);
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked by the count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/fp_div_dispatch.sv
// Issue stage for a fixed-latency FP32 divider: special cases resolved locally, results returned in order.
// Latency DIV_LAT edges accept-to-out_valid; in_ready reserves a FIFO slot per op so backpressure never drops results.
module fp_div_dispatch
  import fp_div_pkg::*;
#(
  parameter int DIV_LAT   = 3,
  parameter int OUT_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  fp_div_dispatch_if.slave   io,
  output logic [31:0]        div_a,
  output logic [31:0]        div_b,
  input  logic [31:0]        div_result
);

  localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
  localparam int FIFO_W = 32 + 2 + TAG_W;

  fp_class_e        cls_a, cls_b;
  logic             sgn;
  logic             spc;
  logic [31:0]      spc_res;
  flags_t           spc_flg;
  logic             acc;

  logic [DIV_LAT-1:0] pipe_vld;
  logic [DIV_LAT-1:0] pipe_spc;
  logic [31:0]        pipe_res [DIV_LAT];
  flags_t             pipe_flg [DIV_LAT];
  logic [TAG_W-1:0]   pipe_tag [DIV_LAT];

  logic [CNT_W-1:0]   fifo_count;
  logic [FIFO_W-1:0]  push_dat;
  logic [FIFO_W-1:0]  head_dat;
  logic               head_vld;
  logic               pop;
  int                 occupancy;

  always_comb begin
    cls_a   = fp_classify(io.in_a);
    cls_b   = fp_classify(io.in_b);
    sgn     = io.in_a[31] ^ io.in_b[31];
    spc     = 1'b1;
    spc_res = '0;
    spc_flg = '0;
    if (cls_a == NAN || cls_b == NAN || (cls_a == ZERO && cls_b == ZERO) ||
        (cls_a == INF && cls_b == INF)) begin
      spc_res         = QNAN;
      spc_flg.invalid = 1'b1;
    end else if (cls_b == ZERO) begin
      // Inf/0 is an exact infinity, only a finite dividend raises divide-by-zero.
      spc_res             = {sgn, POS_INF[30:0]};
      spc_flg.div_by_zero = (cls_a == NORMAL);
    end else if (cls_a == ZERO || cls_b == INF) begin
      spc_res = {sgn, 31'b0};
    end else if (cls_a == INF) begin
      spc_res = {sgn, POS_INF[30:0]};
    end else begin
      spc = 1'b0;
    end
  end

  // Every queued or in-flight op already owns a FIFO slot.
  always_comb begin
    occupancy = int'(fifo_count);
    for (int i = 0; i < DIV_LAT; i++) occupancy += int'(pipe_vld[i]);
  end

  assign io.in_ready = !reset && (occupancy < OUT_DEPTH);
  assign acc         = io.in_valid && io.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_a    <= '0;
      div_b    <= '0;
      pipe_vld <= '0;
      pipe_spc <= '0;
      for (int i = 0; i < DIV_LAT; i++) begin
        pipe_res[i] <= '0;
        pipe_flg[i] <= '0;
        pipe_tag[i] <= '0;
      end
    end else begin
      if (acc && !spc) begin
        div_a <= io.in_a;
        div_b <= io.in_b;
      end
      pipe_vld[0] <= acc;
      pipe_spc[0] <= spc;
      pipe_res[0] <= spc_res;
      pipe_flg[0] <= spc_flg;
      pipe_tag[0] <= io.in_tag;
      for (int i = 1; i < DIV_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_spc[i] <= pipe_spc[i-1];
        pipe_res[i] <= pipe_res[i-1];
        pipe_flg[i] <= pipe_flg[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  // The last stage lines up with the edge at which the divider result for that op is valid.
  assign push_dat = {pipe_spc[DIV_LAT-1] ? pipe_res[DIV_LAT-1] : div_result,
                     pipe_flg[DIV_LAT-1], pipe_tag[DIV_LAT-1]};
  assign pop      = head_vld && io.out_ready;

  fp_result_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pipe_vld[DIV_LAT-1]),
    .push_dat (push_dat),
    .pop      (pop),
    .head_vld (head_vld),
    .head_dat (head_dat),
    .count    (fifo_count)
  );

  assign io.out_valid  = head_vld;
  assign io.out_result = head_dat[FIFO_W-1 -: 32];
  assign io.out_flags  = head_dat[TAG_W +: 2];
  assign io.out_tag    = head_dat[TAG_W-1:0];

endmodule

// File: tb/tb_fp_div_dispatch.sv
// Directed bench for fp_div_dispatch with a fixed-latency table-driven stand-in for the divider.
module tb_fp_div_dispatch;
  import fp_div_pkg::*;

  localparam int DIV_LAT   = 3;
  localparam int OUT_DEPTH = 4;
  localparam int TAG_W     = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] div_a, div_b, div_result;
  int          n_vec = 0;
  int          n_err = 0;

  fp_div_dispatch_if #(.TAG_W(TAG_W)) io ();

  fp_div_dispatch #(.DIV_LAT(DIV_LAT), .OUT_DEPTH(OUT_DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .io         (io),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_result (div_result)
  );

  always #5 clk = ~clk;

  // Divider stand-in: quotients of the operand pairs used below, DIV_LAT edges after div_a/div_b change.
  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h4010_0000, 32'h3FC0_0000}: return 32'h3FC0_0000;
      {32'h3F80_0000, 32'h3E80_0000}: return 32'h4080_0000;
      {32'hC0A0_0000, 32'h4020_0000}: return 32'hC000_0000;
      {32'h4040_0000, 32'h3F80_0000}: return 32'h4040_0000;
      {32'h4120_0000, 32'h4000_0000}: return 32'h40A0_0000;
      {32'h40C0_0000, 32'h4040_0000}: return 32'h4000_0000;
      {32'h4100_0000, 32'h4080_0000}: return 32'h4000_0000;
      default:                        return 32'hDEAD_BEEF;
    endcase
  endfunction

  logic [31:0] dpipe [DIV_LAT-1];
  always @(posedge clk) begin
    dpipe[0] <= quot(div_a, div_b);
    for (int i = 1; i < DIV_LAT - 1; i++) dpipe[i] <= dpipe[i-1];
  end
  assign div_result = dpipe[DIV_LAT-2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Call at #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    bit done = 1'b0;
    io.in_a     = a;
    io.in_b     = b;
    io.in_tag   = t;
    io.in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = io.in_ready;
      @(posedge clk);
      #1;
    end
    io.in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_out(input string nm, input logic [31:0] r, input logic [1:0] f,
                            input logic [3:0] t);
    bit got = 1'b0;
    logic [1:0] fl;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = io.out_valid;
    end
    chk({nm, "_vld"}, 32'(got), 32'd1);
    if (got) begin
      fl = io.out_flags;
      chk({nm, "_res"}, io.out_result, r);
      chk({nm, "_flg"}, 32'(fl), 32'(f));
      chk({nm, "_tag"}, 32'(io.out_tag), 32'(t));
      io.out_ready = 1'b1;
      @(posedge clk);
      #1;
      io.out_ready = 1'b0;
    end
  endtask

  logic [31:0] sp_a [9], sp_b [9], sp_r [9];
  logic [1:0]  sp_f [9];
  logic [31:0] st_a [4], st_b [4], st_r [4];

  initial begin
    int lat, acc_n, vld_seen;
    bit rdy;

    sp_a[0] = 32'h7F80_0000; sp_b[0] = 32'h0000_0000; sp_r[0] = 32'h7F80_0000; sp_f[0] = 2'b00;
    sp_a[1] = 32'hFF80_0000; sp_b[1] = 32'h0000_0000; sp_r[1] = 32'hFF80_0000; sp_f[1] = 2'b00;
    sp_a[2] = 32'h0000_0000; sp_b[2] = 32'hC000_0000; sp_r[2] = 32'h8000_0000; sp_f[2] = 2'b00;
    sp_a[3] = 32'h3F80_0000; sp_b[3] = 32'h7F80_0000; sp_r[3] = 32'h0000_0000; sp_f[3] = 2'b00;
    sp_a[4] = 32'h7F80_0000; sp_b[4] = 32'h7F80_0000; sp_r[4] = 32'h7FC0_0000; sp_f[4] = 2'b10;
    sp_a[5] = 32'h7F80_0000; sp_b[5] = 32'hC000_0000; sp_r[5] = 32'hFF80_0000; sp_f[5] = 2'b00;
    sp_a[6] = 32'h0000_0001; sp_b[6] = 32'h3F80_0000; sp_r[6] = 32'h0000_0000; sp_f[6] = 2'b00;
    sp_a[7] = 32'hBF80_0000; sp_b[7] = 32'h8000_0000; sp_r[7] = 32'h7F80_0000; sp_f[7] = 2'b01;
    sp_a[8] = 32'h3F80_0000; sp_b[8] = 32'hFFC0_0001; sp_r[8] = 32'h7FC0_0000; sp_f[8] = 2'b10;

    st_a[0] = 32'h4010_0000; st_b[0] = 32'h3FC0_0000; st_r[0] = 32'h3FC0_0000;
    st_a[1] = 32'h3F80_0000; st_b[1] = 32'h3E80_0000; st_r[1] = 32'h4080_0000;
    st_a[2] = 32'hC0A0_0000; st_b[2] = 32'h4020_0000; st_r[2] = 32'hC000_0000;
    st_a[3] = 32'h4100_0000; st_b[3] = 32'h4080_0000; st_r[3] = 32'h4000_0000;

    reset        = 1'b1;
    io.in_valid  = 1'b0;
    io.in_a      = '0;
    io.in_b      = '0;
    io.in_tag    = '0;
    io.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",   32'(io.in_ready), 32'd0);
    chk("rst_out_valid",  32'(io.out_valid), 32'd0);
    chk("rst_out_result", io.out_result, 32'd0);
    chk("rst_div_a",      div_a, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready",  32'(io.in_ready), 32'd1);
    chk("idle_out_valid", 32'(io.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Single normal divide: latency and value.
    send(32'h4010_0000, 32'h3FC0_0000, 4'd1);
    chk("t1_div_a", div_a, 32'h4010_0000);
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      if (io.out_valid) lat = -k;
      else begin
        @(posedge clk);
        #1;
        if (io.out_valid) lat = k;
      end
    end
    chk("t1_latency", 32'(lat), 32'(DIV_LAT));
    expect_out("t1", 32'h3FC0_0000, 2'b00, 4'd1);

    // Back-to-back normal divides.
    send(32'h3F80_0000, 32'h3E80_0000, 4'd2);
    send(32'hC0A0_0000, 32'h4020_0000, 4'd3);
    expect_out("t2a", 32'h4080_0000, 2'b00, 4'd2);
    expect_out("t2b", 32'hC000_0000, 2'b00, 4'd3);

    // Specials leave the divider operands alone.
    send(32'h3F80_0000, 32'h0000_0000, 4'd4);
    expect_out("t3_dbz", 32'h7F80_0000, 2'b01, 4'd4);
    send(32'h0000_0000, 32'h0000_0000, 4'd5);
    expect_out("t3_zz", 32'h7FC0_0000, 2'b10, 4'd5);
    chk("t3_div_a", div_a, 32'hC0A0_0000);
    chk("t3_div_b", div_b, 32'h4020_0000);

    // Special sandwiched between normals keeps issue order.
    send(32'h4040_0000, 32'h3F80_0000, 4'd6);
    send(32'h7FC0_0000, 32'h3F80_0000, 4'd7);
    send(32'h4120_0000, 32'h4000_0000, 4'd8);
    expect_out("t4a", 32'h4040_0000, 2'b00, 4'd6);
    expect_out("t4b", 32'h7FC0_0000, 2'b10, 4'd7);
    expect_out("t4c", 32'h40A0_0000, 2'b00, 4'd8);

    for (int i = 0; i < 9; i++) begin
      send(sp_a[i], sp_b[i], 4'(i));
      expect_out($sformatf("sp%0d", i), sp_r[i], sp_f[i], 4'(i));
    end

    // Stalled consumer: only OUT_DEPTH ops may be admitted.
    acc_n = 0;
    io.in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      io.in_a   = st_a[acc_n % 4];
      io.in_b   = st_b[acc_n % 4];
      io.in_tag = 4'(10 + acc_n);
      @(negedge clk);
      rdy = io.in_ready;
      @(posedge clk);
      #1;
      if (rdy) acc_n++;
    end
    io.in_valid = 1'b0;
    chk("t5_accepts", 32'(acc_n), 32'(OUT_DEPTH));
    @(negedge clk);
    chk("t5_full_in_ready", 32'(io.in_ready), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      expect_out($sformatf("t5_%0d", i), st_r[i], 2'b00, 4'(10 + i));
    @(negedge clk);
    chk("t5_drained_in_ready", 32'(io.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Reset with three ops in flight.
    send(32'h4040_0000, 32'h3F80_0000, 4'd1);
    send(32'h4120_0000, 32'h4000_0000, 4'd2);
    send(32'h3F80_0000, 32'h0000_0000, 4'd3);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_in_ready_rst", 32'(io.in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    vld_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (io.out_valid) vld_seen++;
    end
    chk("t6_no_output", 32'(vld_seen), 32'd0);
    chk("t6_in_ready", 32'(io.in_ready), 32'd1);
    chk("t6_div_a", div_a, 32'd0);
    @(posedge clk);
    #1;
    send(32'h40C0_0000, 32'h4040_0000, 4'd15);
    expect_out("t6_after", 32'h4000_0000, 2'b00, 4'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
